// File: rtl/spi_slave_sync.sv
// spi_slave_sync: clk-domain SPI slave with synchronised sclk/cs/mosi; SPI_RX_OVERRUN_EN adds a sticky rx_overrun flag
module spi_slave_sync #(
  parameter int WIDTH       = 16,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ack,
  output logic             rx_overrun
);
  localparam int CW = $clog2(WIDTH);
  localparam int FW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic IDLE_LVL = 1'(CPOL);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_d;
  logic [SYNC_STAGES-1:0] sclk_sr, cs_sr, mosi_sr;
  logic sclk_q, cs_q;
  logic [FW-1:0] flush;
  logic [WIDTH-1:0] hold, tx_sr, rx_sr, load_word, rx_word;
  logic [CW-1:0] cnt;
  logic miso_r;
  logic sclk_s, cs_s, mosi_s, lead, trail, sample, shift, cs_fall, cs_rise, active, enter, run, done;
  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign cs_s      = cs_sr[SYNC_STAGES-1];
  assign mosi_s    = mosi_sr[SYNC_STAGES-1];
  assign lead      = (sclk_s != IDLE_LVL) && (sclk_q == IDLE_LVL);
  assign trail     = (sclk_s == IDLE_LVL) && (sclk_q != IDLE_LVL);
  assign sample    = (CPHA != 0) ? trail : lead;
  assign shift     = (CPHA != 0) ? lead : trail;
  // The post-reset flush window hides the fake cs fall caused by the chain refilling from its reset value
  assign cs_fall   = !cs_s && cs_q && (flush == '0);
  assign cs_rise   = cs_s && !cs_q;
  assign active    = (state == ACTIVE);
  assign enter     = !active && cs_fall;
  assign run       = active && !cs_rise;
  assign done      = run && sample && (cnt == LAST);
  assign load_word = tx_ready ? '0 : hold;
  assign rx_word   = {rx_sr[WIDTH-2:0], mosi_s};
  assign miso      = active ? miso_r : 1'b0;
  // Synchronisers plus one-cycle history for edge detection
  always_ff @(posedge clk)
    if (reset) begin
      sclk_sr <= {SYNC_STAGES{IDLE_LVL}};
      cs_sr   <= '1;
      mosi_sr <= '0;
      sclk_q  <= IDLE_LVL;
      cs_q    <= 1'b1;
      flush   <= FW'(SYNC_STAGES + 1);
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      sclk_q  <= sclk_s;
      cs_q    <= cs_s;
      if (flush != '0) flush <= flush - 1'b1;
    end
  // Frame state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_d;
  // Enter a frame on cs falling, leave on cs rising
  always_comb begin
    state_d = state;
    state_d = (!active && cs_fall) ? ACTIVE : (active && cs_rise) ? IDLE : state;
  end
  // Shift registers, bit counter, holding register and receive handshake
  always_ff @(posedge clk)
    if (reset) begin
      hold     <= '0;
      tx_ready <= 1'b1;
      tx_sr    <= '0;
      rx_sr    <= '0;
      cnt      <= '0;
      miso_r   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (tx_load && tx_ready) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end
      if ((enter || done) && !tx_ready) tx_ready <= 1'b1;
      if (rx_ack) rx_valid <= 1'b0;
      if (enter) begin
        tx_sr  <= (CPHA != 0) ? load_word : load_word << 1;
        miso_r <= (CPHA != 0) ? 1'b0 : load_word[WIDTH-1];
        cnt    <= '0;
        rx_sr  <= '0;
      end else if (run && sample) begin
        rx_sr <= rx_word;
        cnt   <= done ? '0 : cnt + 1'b1;
        if (done) begin
          rx_data  <= rx_word;
          rx_valid <= 1'b1;
          tx_sr    <= load_word;
        end
      end else if (run && shift) begin
        miso_r <= tx_sr[WIDTH-1];
        tx_sr  <= tx_sr << 1;
      end
    end
`ifdef SPI_RX_OVERRUN_EN
  logic ovr;
  // Sticky: a completed word replaced one the consumer never acknowledged
  always_ff @(posedge clk)
    if (reset) ovr <= 1'b0;
    else if (done && rx_valid && !rx_ack) ovr <= 1'b1;
  assign rx_overrun = ovr;
`else
  assign rx_overrun = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: directed bench, mode 0 DUT (index 0) and mode 3 DUT (index 1)
module tb_spi_slave_sync;
  logic clk = 1'b0, reset = 1'b1, mosi = 1'b0;
  logic [1:0] sclk_v = 2'b10, cs_v = 2'b11, load_v = 2'b00, ack_v = 2'b00;
  logic [15:0] tx_data = '0;
  logic [1:0] miso_v, ready_v, valid_v, ovr_v;
  logic [15:0] rx0, rx1, got;
  int checks = 0, errors = 0;
`ifdef SPI_RX_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif
  always #5 clk = ~clk;
  spi_slave_sync #(.WIDTH(16), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) d0 (
    .clk(clk), .reset(reset), .sclk(sclk_v[0]), .cs(cs_v[0]), .mosi(mosi), .miso(miso_v[0]),
    .tx_data(tx_data), .tx_load(load_v[0]), .tx_ready(ready_v[0]), .rx_data(rx0),
    .rx_valid(valid_v[0]), .rx_ack(ack_v[0]), .rx_overrun(ovr_v[0]));
  spi_slave_sync #(.WIDTH(16), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) d1 (
    .clk(clk), .reset(reset), .sclk(sclk_v[1]), .cs(cs_v[1]), .mosi(mosi), .miso(miso_v[1]),
    .tx_data(tx_data), .tx_load(load_v[1]), .tx_ready(ready_v[1]), .rx_data(rx1),
    .rx_valid(valid_v[1]), .rx_ack(ack_v[1]), .rx_overrun(ovr_v[1]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask
  // MCU side: both modes change mosi on falling sclk and sample miso on rising sclk
  task automatic xfer(input int m, input logic [15:0] w, input int n, output logic [15:0] g);
    g = '0;
    for (int i = 0; i < n; i++) begin
      mosi = w[15-i];
      if (m == 1) sclk_v[1] = 1'b0;
      ticks(4);
      g = {g[14:0], miso_v[m]};
      sclk_v[m] = 1'b1;
      ticks(4);
      if (m == 0) sclk_v[0] = 1'b0;
    end
  endtask
  task automatic cs_set(input int m, input logic v);
    cs_v[m] = v;
    ticks(4);
  endtask
  task automatic load(input int m, input logic [15:0] w);
    tx_data = w;
    load_v[m] = 1'b1;
    ticks(1);
    load_v[m] = 1'b0;
  endtask
  task automatic ack(input int m);
    ack_v[m] = 1'b1;
    ticks(1);
    ack_v[m] = 1'b0;
  endtask
  initial begin
    ticks(3);
    reset = 1'b0;
    ticks(5);
    chk("rst_miso", miso_v[0], 0);
    chk("rst_tx_ready", ready_v[0], 1);
    chk("rst_rx_valid", valid_v[0], 0);
    chk("rst_rx_data", rx0, 0);
    chk("rst_overrun", ovr_v[0], 0);
    load(0, 16'h1234);
    chk("m0_ready_after_load", ready_v[0], 0);
    load(0, 16'hFFFF);
    cs_set(0, 1'b0);
    chk("m0_ready_after_entry", ready_v[0], 1);
    xfer(0, 16'hA53C, 16, got);
    chk("m0_rx_valid", valid_v[0], 1);
    chk("m0_rx_data", rx0, 16'hA53C);
    chk("m0_miso_word", got, 16'h1234);
    cs_set(0, 1'b1);
    chk("m0_miso_idle", miso_v[0], 0);
    ack(0);
    chk("m0_ack_clears", valid_v[0], 0);
    cs_set(0, 1'b0);
    xfer(0, 16'h5500, 7, got);
    cs_set(0, 1'b1);
    chk("partial_no_valid", valid_v[0], 0);
    chk("partial_data_kept", rx0, 16'hA53C);
    cs_set(0, 1'b0);
    xfer(0, 16'h00FF, 16, got);
    chk("full_after_partial", rx0, 16'h00FF);
    chk("full_valid", valid_v[0], 1);
    chk("empty_hold_zeros", got, 16'h0000);
    ack(0);
    xfer(0, 16'h1111, 16, got);
    chk("ovr_first_valid", valid_v[0], 1);
    chk("ovr_first_no_flag", ovr_v[0], 0);
    xfer(0, 16'h2222, 16, got);
    cs_set(0, 1'b1);
    chk("ovr_data", rx0, 16'h2222);
    chk("ovr_valid", valid_v[0], 1);
    chk("ovr_flag", ovr_v[0], OVR_EXP);
    load(1, 16'h5A5A);
    cs_set(1, 1'b0);
    xfer(1, 16'hBEEF, 16, got);
    chk("m3_w1_valid", valid_v[1], 1);
    chk("m3_w1_data", rx1, 16'hBEEF);
    chk("m3_w1_miso", got, 16'h5A5A);
    ack(1);
    chk("m3_ack_clears", valid_v[1], 0);
    xfer(1, 16'h0001, 16, got);
    chk("m3_w2_valid", valid_v[1], 1);
    chk("m3_w2_data", rx1, 16'h0001);
    chk("m3_w2_miso_zero", got, 16'h0000);
    cs_set(1, 1'b1);
    chk("m3_miso_idle", miso_v[1], 0);
    chk("m3_ready", ready_v[1], 1);
    cs_set(0, 1'b0);
    load(0, 16'h7777);
    chk("mid_ready_low", ready_v[0], 0);
    xfer(0, 16'hFFFF, 9, got);
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    ticks(1);
    chk("mid_rst_valid", valid_v[0], 0);
    chk("mid_rst_data", rx0, 0);
    chk("mid_rst_ready", ready_v[0], 1);
    chk("mid_rst_miso", miso_v[0], 0);
    chk("mid_rst_overrun", ovr_v[0], 0);
    ticks(6);
    xfer(0, 16'h5555, 16, got);
    chk("no_frame_without_fall", valid_v[0], 0);
    cs_set(0, 1'b1);
    cs_set(0, 1'b0);
    xfer(0, 16'hC3C3, 16, got);
    cs_set(0, 1'b1);
    chk("post_rst_data", rx0, 16'hC3C3);
    chk("post_rst_valid", valid_v[0], 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
